// File: rtl/lc4_alu_mc.sv
// lc4_alu_mc: multi-cycle LC4 ALU for the execute stage, valid/ready on both sides.
// Ports: clk, rst_n (async low); i_valid/o_ready accept side; i_insn, i_pc,
//   i_r1data, i_r2data operands; i_flush aborts in-flight work; o_valid/i_ready
//   result side; o_result, o_busy (iterating), o_div0 (divide/mod by zero).
// Build option: LC4_ALU_ITER_MUL_EN selects an iterative shift-add MUL.
module lc4_alu_mc #(
    parameter int DATA_W   = 16,
    parameter int DIV_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [15:0]       i_insn,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_r1data,
    input  logic [DATA_W-1:0] i_r2data,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_result,
    output logic              o_busy,
    output logic              o_div0
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W / DIV_STEP - 1);
`ifdef LC4_ALU_ITER_MUL_EN
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    typedef enum logic [1:0] {K_DIV, K_MOD, K_MUL} kind_e;

    state_e state_q, state_d;
    kind_e  kind_q;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  iter_last;
    logic [DATA_W:0]   rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] result_q;
    logic              div0_q;

    logic accept;
    logic iter_fin;

    // ------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------
    logic [3:0] opc;
    logic       is_div;
    logic       is_mod;
    logic       div_zero;
    logic       go_iter;

    assign opc      = i_insn[15:12];
    assign is_div   = (opc == 4'b0001) && (i_insn[5:3] == 3'b011);
    assign is_mod   = (opc == 4'b1010) && (i_insn[5:4] == 2'b11);
    assign div_zero = (is_div || is_mod) && (i_r2data == '0);

`ifdef LC4_ALU_ITER_MUL_EN
    logic is_mul;
    assign is_mul  = (opc == 4'b0001) && (i_insn[5:3] == 3'b001);
    assign go_iter = ((is_div || is_mod) && !div_zero) || is_mul;
`else
    assign go_iter = (is_div || is_mod) && !div_zero;
`endif

    // ------------------------------------------------------------
    // Immediates
    // ------------------------------------------------------------
    logic [DATA_W-1:0] sext5;
    logic [DATA_W-1:0] sext6;
    logic [DATA_W-1:0] sext7;
    logic [DATA_W-1:0] sext9;
    logic [DATA_W-1:0] sext11;
    logic [DATA_W-1:0] uimm7;
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] msb;

    assign sext5  = {{(DATA_W-5){i_insn[4]}}, i_insn[4:0]};
    assign sext6  = {{(DATA_W-6){i_insn[5]}}, i_insn[5:0]};
    assign sext7  = {{(DATA_W-7){i_insn[6]}}, i_insn[6:0]};
    assign sext9  = {{(DATA_W-9){i_insn[8]}}, i_insn[8:0]};
    assign sext11 = {{(DATA_W-11){i_insn[10]}}, i_insn[10:0]};
    assign uimm7  = DATA_W'(i_insn[6:0]);
    assign pc_inc = i_pc + DATA_W'(1);
    assign msb    = {1'b1, {(DATA_W-1){1'b0}}};

    // All compares: all-ones for lt, 0 for eq, 1 for gt.
    function automatic logic [DATA_W-1:0] cmp(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              sgn
    );
        logic lt;
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        if (a == b)
            return '0;
        else if (lt)
            return '1;
        else
            return DATA_W'(1);
    endfunction

    // ------------------------------------------------------------
    // Single-cycle result
    // ------------------------------------------------------------
    logic [DATA_W-1:0] alu_res;

    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            (opc == 4'h0): alu_res = pc_inc + sext9;
            (opc == 4'h1): begin
                if (i_insn[5]) begin
                    alu_res = i_r1data + sext5;
                end else begin
                    case (i_insn[4:3])
                        2'b00: alu_res = i_r1data + i_r2data;
`ifdef LC4_ALU_ITER_MUL_EN
                        2'b01: alu_res = '0;
`else
                        2'b01: alu_res = i_r1data * i_r2data;
`endif
                        2'b10: alu_res = i_r1data + ~i_r2data + DATA_W'(1);
                        default: alu_res = '0;
                    endcase
                end
            end
            (opc == 4'h2): begin
                case (i_insn[8:7])
                    2'b00: alu_res = cmp(i_r1data, i_r2data, 1'b1);
                    2'b01: alu_res = cmp(i_r1data, i_r2data, 1'b0);
                    2'b10: alu_res = cmp(i_r1data, sext7, 1'b1);
                    default: alu_res = cmp(i_r1data, uimm7, 1'b0);
                endcase
            end
            (opc == 4'h4): begin
                if (i_insn[11])
                    alu_res = (i_pc & msb) | DATA_W'({i_insn[10:0], 4'b0000});
                else
                    alu_res = i_r1data;
            end
            (opc == 4'h5): begin
                if (i_insn[5]) begin
                    alu_res = i_r1data & sext5;
                end else begin
                    case (i_insn[4:3])
                        2'b00: alu_res = i_r1data & i_r2data;
                        2'b01: alu_res = ~i_r1data;
                        2'b10: alu_res = i_r1data | i_r2data;
                        default: alu_res = i_r1data ^ i_r2data;
                    endcase
                end
            end
            (opc == 4'h6),
            (opc == 4'h7): alu_res = i_r1data + sext6;
            (opc == 4'h8): alu_res = i_r1data;
            (opc == 4'h9): alu_res = sext9;
            (opc == 4'hA): begin
                case (i_insn[5:4])
                    2'b00: alu_res = i_r1data << i_insn[3:0];
                    2'b01: alu_res = DATA_W'($signed(i_r1data) >>> i_insn[3:0]);
                    2'b10: alu_res = i_r1data >> i_insn[3:0];
                    default: alu_res = '0;
                endcase
            end
            (opc == 4'hC): begin
                if (i_insn[11])
                    alu_res = pc_inc + sext11;
                else
                    alu_res = i_r1data;
            end
            (opc == 4'hD): alu_res = DATA_W'({i_insn[7:0], i_r1data[7:0]});
            (opc == 4'hF): alu_res = msb | DATA_W'(i_insn[7:0]);
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------
    // Iterative step: restoring divider (and shift-add multiplier)
    // rem_q/quo_q/dvs_q double as acc/multiplier/multiplicand for MUL.
    // ------------------------------------------------------------
    logic [DATA_W:0]   step_rem;
    logic [DATA_W-1:0] step_quo;
    logic [DATA_W-1:0] step_dvs;
    logic [DATA_W:0]   r;
    logic [DATA_W-1:0] q;

    always_comb begin
        r = rem_q;
        q = quo_q;
        // Shift the next dividend bit into the partial remainder;
        // subtract when it fits and record a quotient one.
        for (int i = 0; i < DIV_STEP; i++) begin
            r = {r[DATA_W-1:0], q[DATA_W-1]};
            q = {q[DATA_W-2:0], 1'b0};
            if (r >= {1'b0, dvs_q}) begin
                r    = r - {1'b0, dvs_q};
                q[0] = 1'b1;
            end
        end
        step_rem = r;
        step_quo = q;
        step_dvs = dvs_q;
`ifdef LC4_ALU_ITER_MUL_EN
        if (kind_q == K_MUL) begin
            step_rem = {1'b0, rem_q[DATA_W-1:0] + (quo_q[0] ? dvs_q : '0)};
            step_quo = quo_q >> 1;
            step_dvs = dvs_q << 1;
        end
`endif
    end

`ifdef LC4_ALU_ITER_MUL_EN
    assign iter_last = (kind_q == K_MUL) ? MUL_LAST : DIV_LAST;
`else
    assign iter_last = DIV_LAST;
`endif

    // ------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        iter_fin = 1'b0;
        o_ready  = 1'b0;
        o_valid  = 1'b0;
        o_busy   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                // A flush in the accept cycle suppresses the accept.
                if (i_valid && !i_flush) begin
                    accept  = 1'b1;
                    state_d = go_iter ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                o_busy = 1'b1;
                if (i_flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == iter_last) begin
                    iter_fin = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_flush || i_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q   <= K_DIV;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            div0_q   <= 1'b0;
        end else if (accept) begin
            result_q <= alu_res;
            div0_q   <= div_zero;
            cnt_q    <= '0;
            kind_q   <= is_mod ? K_MOD : K_DIV;
            rem_q    <= '0;
            quo_q    <= i_r1data;
            dvs_q    <= i_r2data;
`ifdef LC4_ALU_ITER_MUL_EN
            if (is_mul) begin
                kind_q <= K_MUL;
                quo_q  <= i_r2data;
                dvs_q  <= i_r1data;
            end
`endif
        end else if (state_q == S_BUSY) begin
            if (i_flush) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= iter_fin ? '0 : cnt_q + CNT_W'(1);
                rem_q <= step_rem;
                quo_q <= step_quo;
                dvs_q <= step_dvs;
                if (iter_fin)
                    result_q <= (kind_q == K_DIV) ? step_quo
                                                  : step_rem[DATA_W-1:0];
            end
        end
    end

    assign o_result = result_q;
    assign o_div0   = div0_q && (state_q == S_DONE);

endmodule

// File: tb/tb_lc4_alu_mc.sv
// tb_lc4_alu_mc: directed self-checking bench for lc4_alu_mc.
// Immediate assertions at every comparison point.
module tb_lc4_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_insn = '0;
    logic [15:0] i_pc = '0;
    logic [15:0] i_r1data = '0;
    logic [15:0] i_r2data = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [15:0] o_result;
    logic        o_busy;
    logic        o_div0;

    int total = 0;
    int bad = 0;
    int lat;
    int busy;

    lc4_alu_mc #(
        .DATA_W  (16),
        .DIV_STEP(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_insn  (i_insn),
        .i_pc    (i_pc),
        .i_r1data(i_r1data),
        .i_r2data(i_r2data),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_result(o_result),
        .o_busy  (o_busy),
        .o_div0  (o_div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one edge; returns in cycle 1 after accept.
    task automatic issue(input logic [15:0] insn, input logic [15:0] pc,
                         input logic [15:0] a, input logic [15:0] b);
        i_insn   = insn;
        i_pc     = pc;
        i_r1data = a;
        i_r2data = b;
        i_valid  = 1'b1;
        tick();
        i_valid  = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [15:0] insn,
                        input logic [15:0] pc, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp);
        issue(insn, pc, a, b);
        chk({tag, "_valid"}, 16'(o_valid), 16'd1);
        chk(tag, o_result, exp);
        tick();
    endtask

    // Counts cycles from cycle 1 until o_valid, bounded.
    task automatic wait_done(output int l, output int nb);
        l  = 1;
        nb = 0;
        while (o_valid !== 1'b1 && l < 40) begin
            if (o_busy === 1'b1)
                nb++;
            tick();
            l++;
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ready", 16'(o_ready), 16'd1);
        chk("rst_valid", 16'(o_valid), 16'd0);
        chk("rst_busy", 16'(o_busy), 16'd0);
        chk("rst_result", o_result, 16'h0000);
        chk("rst_div0", 16'(o_div0), 16'd0);
        #10 rst_n = 1'b1;
        tick();

        // ADD overflow wrap, ready back on cycle 2
        issue(16'h1000, 16'h0, 16'h7FFF, 16'h0001);
        chk("add_valid", 16'(o_valid), 16'd1);
        chk("add_ready_c1", 16'(o_ready), 16'd0);
        chk("add", o_result, 16'h8000);
        tick();
        chk("add_ready_c2", 16'(o_ready), 16'd1);
        chk("add_valid_c2", 16'(o_valid), 16'd0);

        // Compares
        run1("cmp", 16'h2000, 16'h0, 16'h8000, 16'h0001, 16'hFFFF);
        run1("cmpu", 16'h2080, 16'h0, 16'h8000, 16'h0001, 16'h0001);
        run1("cmpi", 16'h2103, 16'h0, 16'h0003, 16'h0000, 16'h0000);

        // Assorted single-cycle ops
        run1("sub", 16'h1010, 16'h0, 16'h0003, 16'h0005, 16'hFFFE);
        run1("mul", 16'h1008, 16'h0, 16'h0123, 16'h0100, 16'h2300);
        run1("addi", 16'h103F, 16'h0, 16'h0005, 16'h0000, 16'h0004);
        run1("andi", 16'h502F, 16'h0, 16'hABCD, 16'h0000, 16'h000D);
        run1("not", 16'h5008, 16'h0, 16'h00FF, 16'h0000, 16'hFF00);
        run1("sra", 16'hA014, 16'h0, 16'h8000, 16'h0000, 16'hF800);
        run1("srl", 16'hA024, 16'h0, 16'h8000, 16'h0000, 16'h0800);
        run1("hiconst", 16'hD1AB, 16'h0, 16'h1234, 16'h0000, 16'hAB34);
        run1("trap", 16'hF025, 16'h0, 16'h0000, 16'h0000, 16'h8025);
        run1("jsr", 16'h4923, 16'h8ABC, 16'h0000, 16'h0000, 16'h9230);
        run1("jmp", 16'hCFFE, 16'h1000, 16'h0000, 16'h0000, 16'h0FFF);
        run1("br", 16'h0FFD, 16'h0010, 16'h0000, 16'h0000, 16'h000E);
        run1("const", 16'h91F0, 16'h0, 16'h0000, 16'h0000, 16'hFFF0);
        run1("ldr", 16'h603F, 16'h0, 16'h0000, 16'h0000, 16'hFFFF);
        run1("jsrr", 16'h4000, 16'h0, 16'h5A5A, 16'h0000, 16'h5A5A);
        run1("unused", 16'h3FFF, 16'h0, 16'h1234, 16'h5678, 16'h0000);

        // DIV 100/7
        issue(16'h1018, 16'h0, 16'd100, 16'd7);
        wait_done(lat, busy);
        chk("div_lat", 16'(lat), 16'd17);
        chk("div_busy", 16'(busy), 16'd16);
        chk("div", o_result, 16'd14);
        chk("div_div0", 16'(o_div0), 16'd0);
        tick();

        // Remainder 100/7
        issue(16'hA030, 16'h0, 16'd100, 16'd7);
        wait_done(lat, busy);
        chk("mod_lat", 16'(lat), 16'd17);
        chk("mod_busy", 16'(busy), 16'd16);
        chk("mod", o_result, 16'd2);
        tick();

        // Wide operands
        issue(16'h1018, 16'h0, 16'hFFFF, 16'h0001);
        wait_done(lat, busy);
        chk("div_ffff", o_result, 16'hFFFF);
        tick();
        issue(16'hA030, 16'h0, 16'hFFFF, 16'h8000);
        wait_done(lat, busy);
        chk("mod_ffff", o_result, 16'h7FFF);
        tick();

        // Divide by zero
        issue(16'h1018, 16'h0, 16'd5, 16'd0);
        chk("div0_valid", 16'(o_valid), 16'd1);
        chk("div0_result", o_result, 16'h0000);
        chk("div0_flag", 16'(o_div0), 16'd1);
        tick();
        issue(16'hA030, 16'h0, 16'd5, 16'd0);
        chk("mod0_valid", 16'(o_valid), 16'd1);
        chk("mod0_result", o_result, 16'h0000);
        chk("mod0_flag", 16'(o_div0), 16'd1);
        tick();
        run1("add_after0", 16'h1000, 16'h0, 16'd1, 16'd1, 16'd2);
        issue(16'h1000, 16'h0, 16'd1, 16'd1);
        chk("div0_clear", 16'(o_div0), 16'd0);
        tick();

        // Flush at cycle 5 of a divide
        issue(16'h1018, 16'h0, 16'hFFFF, 16'd3);
        repeat (4) tick();
        chk("fl_busy_c5", 16'(o_busy), 16'd1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("fl_ready_c6", 16'(o_ready), 16'd1);
        chk("fl_valid_c6", 16'(o_valid), 16'd0);
        chk("fl_busy_c6", 16'(o_busy), 16'd0);
        issue(16'h1000, 16'h0, 16'd2, 16'd3);
        chk("fl_add_valid", 16'(o_valid), 16'd1);
        chk("fl_add", o_result, 16'd5);
        tick();

        // Flush with valid in IDLE: nothing accepted
        i_flush = 1'b1;
        issue(16'h1000, 16'h0, 16'd9, 16'd9);
        i_flush = 1'b0;
        chk("flv_ready", 16'(o_ready), 16'd1);
        chk("flv_valid", 16'(o_valid), 16'd0);

        // Back-pressure: hold i_ready low for 4 cycles
        i_ready = 1'b0;
        issue(16'h1000, 16'h0, 16'd1, 16'd2);
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", 16'(o_valid), 16'd1);
            chk("bp_result", o_result, 16'd3);
            chk("bp_ready", 16'(o_ready), 16'd0);
            tick();
        end
        chk("bp_hold_valid", 16'(o_valid), 16'd1);
        i_ready = 1'b1;
        tick();
        chk("bp_release", 16'(o_ready), 16'd1);

        // Async reset during BUSY
        issue(16'h1018, 16'h0, 16'd100, 16'd7);
        repeat (3) tick();
        chk("rb_busy", 16'(o_busy), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rb_busy0", 16'(o_busy), 16'd0);
        chk("rb_valid", 16'(o_valid), 16'd0);
        chk("rb_ready", 16'(o_ready), 16'd1);
        chk("rb_result", o_result, 16'h0000);
        chk("rb_div0", 16'(o_div0), 16'd0);
        #2 rst_n = 1'b1;
        tick();

        // Recovery after reset
        issue(16'hA030, 16'h0, 16'd100, 16'd7);
        wait_done(lat, busy);
        chk("rec_lat", 16'(lat), 16'd17);
        chk("rec_mod", o_result, 16'd2);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
